// File: rtl/sum_acc_pkg.sv
// ============================================================================
// Module   : sum_acc_pkg
// Brief    : Shared types, width defaults and adder helper for sum_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int SUM_DATA_W = 8;
  localparam int SUM_ACC_W  = 16;
  // Widest accumulator the helper supports; ACC_W must stay strictly below it.
  localparam int SUM_MAX_W  = 32;

  // Returns {carry, result}. Operands are already below 2**acc_w, so every
  // sum bit above the mask is the carry out of bit acc_w-1.
  function automatic logic [SUM_MAX_W:0] sat_add(
    input logic [SUM_MAX_W-1:0] acc,
    input logic [SUM_MAX_W-1:0] data,
    input int                   acc_w,
    input logic                 sat
  );
    logic [SUM_MAX_W:0] mask;
    logic [SUM_MAX_W:0] sum;
    logic [SUM_MAX_W:0] res;
    logic               carry;
    mask  = ({{SUM_MAX_W{1'b0}}, 1'b1} << acc_w) - {{SUM_MAX_W{1'b0}}, 1'b1};
    sum   = {1'b0, acc} + {1'b0, data};
    carry = |(sum & ~mask);
    res   = (sat && carry) ? mask : (sum & mask);
    return {carry, res[SUM_MAX_W-1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sum_acc_counter.sv
// ============================================================================
// Module   : sum_acc_counter
// Brief    : Frame transfer counter with terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_acc_counter #(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic last
);

  localparam int CNT_W = $clog2(COUNT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The next transfer completes the frame.
  assign last = (r_cnt == CNT_W'(COUNT - 1));

endmodule

`default_nettype wire

// File: rtl/sum_accumulator.sv
// ============================================================================
// Module   : sum_accumulator
// Brief    : Frames COUNT adder results into one ACC_W total with overflow flag.
//            Define SUM_ACCUMULATOR_SATURATE_EN to clamp instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = SUM_DATA_W,
  parameter int ACC_W  = SUM_ACC_W,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_ovf
);

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_e             r_state;
  state_e             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic               w_xfer;
  logic               w_accept;
  logic               w_last;
  logic [SUM_MAX_W:0] w_add;
  logic               w_add_unused;

  assign w_xfer   = s_valid && s_ready;
  assign w_accept = (r_state == OUT) && m_ready;

  sum_acc_counter #(
    .COUNT (COUNT)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_xfer),
    .clr  (w_accept),
    .last (w_last)
  );

  // Once clamped, further carries (or zero adds) keep acc at full scale.
  assign w_add = sat_add(SUM_MAX_W'(r_acc), SUM_MAX_W'(s_data), ACC_W, SAT_EN);
  assign w_add_unused = ^w_add[SUM_MAX_W-1:ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACC: if (w_xfer) w_next = w_last ? OUT : ACC;
      OUT:       if (m_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    if (r_state == OUT) begin
      s_ready = 1'b0;
      m_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      if (r_state == IDLE) begin
        r_acc <= ACC_W'(s_data);
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_add[ACC_W-1:0];
        r_ovf <= r_ovf | w_add[SUM_MAX_W];
      end
    end else if (w_accept) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign m_data = r_acc;
  assign m_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
// Module   : tb_sum_accumulator
// Brief    : Directed self-checking bench for sum_accumulator (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Default configuration
  logic [7:0]  s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_ovf;

  sum_accumulator dut (
    .clk (clk), .rst (rst),
    .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready), .m_ovf (m_ovf)
  );

  // Narrow accumulator
  logic [7:0] w9_s_data  = '0;
  logic       w9_s_valid = 1'b0;
  logic       w9_s_ready;
  logic [8:0] w9_m_data;
  logic       w9_m_valid;
  logic       w9_m_ready = 1'b0;
  logic       w9_m_ovf;

  sum_accumulator #(.DATA_W(8), .ACC_W(9), .COUNT(4)) dut9 (
    .clk (clk), .rst (rst),
    .s_data (w9_s_data), .s_valid (w9_s_valid), .s_ready (w9_s_ready),
    .m_data (w9_m_data), .m_valid (w9_m_valid), .m_ready (w9_m_ready), .m_ovf (w9_m_ovf)
  );

  // Single-transfer frames
  logic [7:0]  c1_s_data  = '0;
  logic        c1_s_valid = 1'b0;
  logic        c1_s_ready;
  logic [15:0] c1_m_data;
  logic        c1_m_valid;
  logic        c1_m_ready = 1'b1;
  logic        c1_m_ovf;

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT(1)) dut1 (
    .clk (clk), .rst (rst),
    .s_data (c1_s_data), .s_valid (c1_s_valid), .s_ready (c1_s_ready),
    .m_data (c1_m_data), .m_valid (c1_m_valid), .m_ready (c1_m_ready), .m_ovf (c1_m_ovf)
  );

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v;
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 'x;
  endtask

  task automatic accept();
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 16'd0) begin n_fail++; $display("FAIL reset_m_data got %0d want 0", m_data); end
    n_cmp++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_m_ovf got %b want 0", m_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    push(8'd3);
    push(8'd7);
    push(8'd11);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got %b want 0", m_valid); end
    push(8'd13);
    idle_in();
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_m_valid got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 16'd34) begin n_fail++; $display("FAIL b2b_m_data got %0d want 34", m_data); end
    n_cmp++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_m_ovf got %b want 0", m_ovf); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_s_ready got %b want 0", s_ready); end
    accept();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_accept_valid got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_after_accept_ready got %b want 1", s_ready); end
  endtask

  task automatic test_idle_gaps();
    logic [7:0] vals [4] = '{8'd3, 8'd7, 8'd11, 8'd13};
    for (int i = 0; i < 4; i++) begin
      push(vals[i]);
      if (i < 3) begin
        idle_in();
        idle_in();
      end
      if (i == 2) begin
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early_valid got %b want 0", m_valid); end
      end
    end
    idle_in();
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_m_valid got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 16'd34) begin n_fail++; $display("FAIL gaps_m_data got %0d want 34", m_data); end
    accept();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_after_accept got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    push(8'd1);
    push(8'd2);
    push(8'd3);
    push(8'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'd99;
      n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid cycle %0d got %b want 1", i, m_valid); end
      n_cmp++; if (m_data !== 16'd10) begin n_fail++; $display("FAIL bp_m_data cycle %0d got %0d want 10", i, m_data); end
      n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready cycle %0d got %b want 0", i, s_ready); end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", s_ready); end
    // 99 is still presented and becomes the first element of the next frame.
    push(8'd1);
    push(8'd1);
    push(8'd1);
    idle_in();
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 16'd102) begin n_fail++; $display("FAIL bp_next_data got %0d want 102", m_data); end
    accept();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w9_s_valid = 1'b1;
      w9_s_data  = 8'd255;
    end
    @(negedge clk);
    w9_s_valid = 1'b0;
    n_cmp++; if (w9_m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_m_valid got %b want 1", w9_m_valid); end
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    n_cmp++; if (w9_m_data !== 9'd511) begin n_fail++; $display("FAIL ovf_m_data got %0d want 511", w9_m_data); end
`else
    n_cmp++; if (w9_m_data !== 9'd508) begin n_fail++; $display("FAIL ovf_m_data got %0d want 508", w9_m_data); end
`endif
    n_cmp++; if (w9_m_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_m_ovf got %b want 1", w9_m_ovf); end
    w9_m_ready = 1'b1;
    @(negedge clk);
    w9_m_ready = 1'b0;
    n_cmp++; if (w9_m_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %b want 0", w9_m_ovf); end
  endtask

  task automatic test_reset_mid_frame();
    push(8'd5);
    push(8'd9);
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    n_cmp++; if (m_data !== 16'd0) begin n_fail++; $display("FAIL midrst_m_data got %0d want 0", m_data); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_s_ready got %b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid got %b want 0", m_valid); end
    n_cmp++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_m_ovf got %b want 0", m_ovf); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(8'd2);
    idle_in();
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_frame_valid got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 16'd8) begin n_fail++; $display("FAIL midrst_frame_data got %0d want 8", m_data); end
    accept();
  endtask

  task automatic test_count_one();
    @(negedge clk);
    c1_s_valid = 1'b1;
    c1_s_data  = 8'd200;
    @(negedge clk);
    c1_s_data  = 8'd17;
    n_cmp++; if (c1_m_valid !== 1'b1) begin n_fail++; $display("FAIL c1_first_valid got %b want 1", c1_m_valid); end
    n_cmp++; if (c1_m_data !== 16'd200) begin n_fail++; $display("FAIL c1_first_data got %0d want 200", c1_m_data); end
    n_cmp++; if (c1_s_ready !== 1'b0) begin n_fail++; $display("FAIL c1_out_ready got %b want 0", c1_s_ready); end
    @(negedge clk);
    n_cmp++; if (c1_s_ready !== 1'b1) begin n_fail++; $display("FAIL c1_idle_ready got %b want 1", c1_s_ready); end
    n_cmp++; if (c1_m_valid !== 1'b0) begin n_fail++; $display("FAIL c1_idle_valid got %b want 0", c1_m_valid); end
    @(negedge clk);
    c1_s_valid = 1'b0;
    n_cmp++; if (c1_m_valid !== 1'b1) begin n_fail++; $display("FAIL c1_second_valid got %b want 1", c1_m_valid); end
    n_cmp++; if (c1_m_data !== 16'd17) begin n_fail++; $display("FAIL c1_second_data got %0d want 17", c1_m_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_idle_gaps();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_count_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
